seq_mul16: RTL and testbench
============================

Name: seq_mul16

Overview:
- Sequential unsigned 16x16 -> 32-bit shift-and-add multiplier for the arithmetic unit.
- Processes one multiplier bit per clock.
- All additions go through the team's existing 16-bit carry-lookahead adder (UAT), instantiated once, cin tied to 0, cout used as the 17th sum bit.
- Sits directly downstream of UAT in the datapath: it consumes UAT's sum and carry and sequences them into a full product, under a start/done handshake.

Parameters:
- WIDTH, 16, operand width. Fixed at 16 to match UAT; other values are not supported.
- CNT_W, 4, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  16  multiplicand; captured on the accepting edge.
- b  input  16  multiplier; captured on the accepting edge.
- busy  output  1  high while iterating.
- done  output  1  single-cycle pulse; product valid.
- product  output  32  result; held until the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, product=0, counter=0, internal M/HI/LO registers=0.
- Registers:
  - M[15:0] holds the multiplicand.
  - HI[15:0] is the partial product.
  - LO[15:0] holds the multiplier, shifting out as product low bits fill in.
- Adder hookup: UAT.a=HI, UAT.b=(LO[0] ? M : 16'h0), cin=0. sum17={cout,res}.
- States:
  - IDLE: start=1 -> M<=a, HI<=0, LO<=b, counter<=0, busy<=1, go BUSY. start=0 -> stay.
  - BUSY, every edge:
    - HI<=sum17[16:1], LO<={sum17[0],LO[15:1]}, counter<=counter+1.
    - When counter==15 on this edge: go DONE, busy<=0, done<=1, product<={sum17[16:1],sum17[0],LO[15:1]}.
  - DONE (one cycle):
    - done=1 for this cycle only.
    - start=1 -> accept as in IDLE (back-to-back): done deasserts, busy asserts on the same edge.
    - start=0 -> IDLE, done<=0.
- Latency:
  - done is high in the cycle after the 16th edge following the accepting edge. The accepting edge is the load; the next 16 edges are the iterations.
  - Fixed latency, no early termination on zero operands.
- start while BUSY is ignored entirely; no queueing, operands not recaptured.
- a/b may change freely after the accepting edge.
- product changes only on the edge that sets done. It is held through IDLE and through the next operation's BUSY phase, until that operation's done edge.
- Width/carry: the 17-bit sum never overflows because HI+M < 2^17. The final 32-bit product is exact for all unsigned inputs; no truncation.
- Reset mid-operation aborts immediately to the reset state; product is cleared to 0.
- busy and done are never high simultaneously.

Test Plan:
- Basic: reset, then a=3, b=5, start for one cycle -> busy=1 for 16 cycles; done pulses one cycle at the 16th edge after acceptance; product=32'h0000000F.
- Max operands: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001. Checks cout propagation through UAT on every iteration.
- Zero and identity, run back-to-back, each taking exactly 16 busy cycles:
  - a=16'h1234, b=0 -> product=0.
  - a=16'h1234, b=1 -> product=32'h00001234.
- Ignored start: a=7, b=9 accepted; at busy cycle 5 assert start with a=b=16'hFFFF -> no effect; product=32'h0000003F; done pulses once.
- Back-to-back: hold start=1 with a=2, b=3, then a=16'h8000, b=2 presented during the done cycle:
  - first done gives product=6;
  - the new operation is accepted on that edge;
  - second done gives product=32'h00010000.
- Reset mid-op: start a=16'hABCD, b=16'h1111; assert rst at busy cycle 8 -> busy, done and product go to 0 immediately (asynchronously). After release, a new op with a=10, b=10 gives product=100.

Source files
------------

// File: rtl/seq_mul16.sv
// seq_mul16: sequential unsigned 16x16->32 shift-and-add multiplier built on the uat adder
module seq_mul16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] m, hi, lo, res;
  logic [CNT_W-1:0] cnt;
  logic cout;
  logic [WIDTH:0] sum17;
  uat u_uat (.a(hi), .b(lo[0] ? m : '0), .cin(1'b0), .res(res), .cout(cout));
  assign sum17 = {cout, res};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        BUSY: begin
          hi  <= sum17[WIDTH:1];
          lo  <= {sum17[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= {sum17[WIDTH:1], sum17[0], lo[WIDTH-1:1]};
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
endmodule

// uat: 16-bit parallel-prefix carry-lookahead adder
module uat (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] res,
  output logic        cout
);
  logic [4:0][15:0] gk, pk;
  logic [16:0] c;
  assign gk[0] = a & b;
  assign pk[0] = a ^ b;
  // each level doubles the span of the group generate/propagate terms
  for (genvar l = 0; l < 4; l++) begin : g_lvl
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_comb
        assign gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
        assign pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
      end else begin : g_pass
        assign gk[l+1][i] = gk[l][i];
        assign pk[l+1][i] = pk[l][i];
      end
    end
  end
  assign c    = {gk[4] | (pk[4] & {16{cin}}), cin};
  assign res  = pk[0] ^ c[15:0];
  assign cout = c[16];
endmodule

// File: tb/tb_seq_mul16.sv
// tb_seq_mul16: scenario tests for seq_mul16 against a plain-arithmetic product model
module tb_seq_mul16;
  logic clk = 0, rst = 0, start = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, done;
  logic [31:0] product;
  int tests = 0, fails = 0;

  seq_mul16 dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                 .busy(busy), .done(done), .product(product));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Presents one request at a negedge and observes until done or timeout; no checking here.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, output int bc,
                        output logic [31:0] p, output bit got, output bit ov);
    a = x; b = y; start = 1; bc = 0; got = 0; ov = 0; p = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = 0;
      if (busy && done) ov = 1;
      if (busy) bc++;
      if (done) begin got = 1; p = product; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk); @(negedge clk);
    tests++;
    if ({busy, done, product} !== 34'd0) begin
      fails++; $display("FAIL reset_state: busy=%b done=%b product=%h, want 0/0/0", busy, done, product);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int bc; logic [31:0] p; bit got, ov;
    run_op(16'd3, 16'd5, bc, p, got, ov);
    tests++;
    if (!got || p !== 32'h0000000F) begin
      fails++; $display("FAIL basic_product: got=%b product=%h want %h", got, p, 32'h0000000F);
    end
    tests++;
    if (bc !== 16 || ov) begin
      fails++; $display("FAIL basic_busy: busy cycles=%0d overlap=%b want 16/0", bc, ov);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 32'h0000000F) begin
      fails++; $display("FAIL basic_pulse: done=%b busy=%b product=%h want 0/0/%h", done, busy, product, 32'hF);
    end
  endtask

  task automatic test_max();
    int bc; logic [31:0] p; bit got, ov;
    run_op(16'hFFFF, 16'hFFFF, bc, p, got, ov);
    tests++;
    if (!got || p !== 32'hFFFE0001 || bc !== 16) begin
      fails++; $display("FAIL max_operands: product=%h busy=%0d want %h/16", p, bc, 32'hFFFE0001);
    end
  endtask

  task automatic test_zero_identity();
    int bc; logic [31:0] p; bit got, ov;
    run_op(16'h1234, 16'h0000, bc, p, got, ov);
    tests++;
    if (!got || p !== 32'h0 || bc !== 16) begin
      fails++; $display("FAIL zero_operand: product=%h busy=%0d want 0/16", p, bc);
    end
    run_op(16'h1234, 16'h0001, bc, p, got, ov);
    tests++;
    if (!got || p !== 32'h00001234 || bc !== 16 || ov) begin
      fails++; $display("FAIL identity_b2b: product=%h busy=%0d ov=%b want %h/16/0", p, bc, ov, 32'h1234);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int bc = 0, dn = 0; logic [31:0] p = 'x;
    a = 16'd7; b = 16'd9; start = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) begin a = 16'hFFFF; b = 16'hFFFF; end
      if (busy) bc++;
      if (done) begin dn++; p = product; end
    end
    tests++;
    if (dn !== 1 || p !== 32'h0000003F || bc !== 16) begin
      fails++; $display("FAIL ignored_start: done pulses=%0d product=%h busy=%0d want 1/%h/16", dn, p, bc, 32'h3F);
    end
  endtask

  task automatic test_back_to_back();
    bit got = 0;
    a = 16'd2; b = 16'd3; start = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    tests++;
    if (!got || product !== 32'd6) begin
      fails++; $display("FAIL b2b_first: got=%b product=%h want 6", got, product);
    end
    a = 16'h8000; b = 16'd2;
    @(negedge clk);
    start = 0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 32'd6) begin
      fails++; $display("FAIL b2b_accept: busy=%b done=%b product=%h want 1/0/6", busy, done, product);
    end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    tests++;
    if (!got || product !== 32'h00010000) begin
      fails++; $display("FAIL b2b_second: got=%b product=%h want %h", got, product, 32'h10000);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int bc; logic [31:0] p; bit got, ov;
    a = 16'hABCD; b = 16'h1111; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if ({busy, done, product} !== 34'd0) begin
      fails++; $display("FAIL reset_mid_op: busy=%b done=%b product=%h want 0/0/0", busy, done, product);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run_op(16'd10, 16'd10, bc, p, got, ov);
    tests++;
    if (!got || p !== 32'd100 || bc !== 16) begin
      fails++; $display("FAIL after_reset: product=%h busy=%0d want %h/16", p, bc, 32'd100);
    end
  endtask

  task automatic test_random();
    int bc; logic [31:0] p; bit got, ov;
    logic [15:0] x, y;
    for (int n = 0; n < 24; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      if (n == 0) x = 16'h0001;
      if (n == 1) y = 16'h8000;
      run_op(x, y, bc, p, got, ov);
      tests++;
      if (!got || p !== model(x, y) || bc !== 16 || ov) begin
        fails++; $display("FAIL random_%0d: %h*%h product=%h busy=%0d ov=%b want %h/16/0", n, x, y, p, bc, ov, model(x, y));
      end
      if (n[0]) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_identity();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
